// File: rtl/rx_sr_pkg.sv
// Shared types and defaults for the receive-side serial-to-parallel assembler.
package rx_sr_pkg;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } rx_state_t;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int BUS_BYTES       = 8;

  function automatic int beats(input int num_in, input int num_out);
    return num_out / num_in;
  endfunction

endpackage

// File: rtl/flexbyte_stp_sr.sv
// Serial-to-parallel byte shifter: each enabled beat enters at the LSBs and
// pushes earlier beats toward the MSBs (mirror of the transmit shifter).
module flexbyte_stp_sr
  import rx_sr_pkg::*;
#(
  parameter int NUM_BYTES_IN  = BUS_BYTES,
  parameter int NUM_BYTES_OUT = AES_BLOCK_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_enable,
  input  logic                       clear,
  input  logic [8*NUM_BYTES_IN-1:0]  data_in,
  output logic [8*NUM_BYTES_OUT-1:0] data_out
);

  localparam int IN_W  = 8 * NUM_BYTES_IN;
  localparam int OUT_W = 8 * NUM_BYTES_OUT;

  logic [OUT_W-1:0] r_sr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (clear) begin
      r_sr <= '0;
    end else if (shift_enable) begin
      r_sr <= {r_sr[OUT_W-IN_W-1:0], data_in};
    end
  end

  assign data_out = r_sr;

endmodule

// File: rtl/rx_sr.sv
// Receive assembler: packs NUM_BYTES_IN beats into NUM_BYTES_OUT blocks with
// a holding stage. Define RX_SR_BYTE_SWAP_EN to byte-reverse each input beat.
module rx_sr
  import rx_sr_pkg::*;
#(
  parameter int NUM_BYTES_IN  = BUS_BYTES,
  parameter int NUM_BYTES_OUT = AES_BLOCK_BYTES,
  localparam int BEATS        = beats(NUM_BYTES_IN, NUM_BYTES_OUT),
  localparam int CNT_W        = $clog2(BEATS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [8*NUM_BYTES_IN-1:0]  data_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [8*NUM_BYTES_OUT-1:0] data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           beat_cnt
);

  localparam int IN_W  = 8 * NUM_BYTES_IN;
  localparam int OUT_W = 8 * NUM_BYTES_OUT;

  if ((NUM_BYTES_OUT % NUM_BYTES_IN) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("rx_sr: NUM_BYTES_OUT must be a multiple (>= 2x) of NUM_BYTES_IN");
  end

  rx_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [OUT_W-1:0] r_hold;
  logic             r_out_valid;

  logic [IN_W-1:0]  w_beat;
  logic [OUT_W-1:0] w_asm, w_asm_next, w_hold_src;
  logic             w_accept, w_consume, w_hold_free, w_last, w_load_hold;

`ifdef RX_SR_BYTE_SWAP_EN
  always_comb begin
    // NOTE: a default before the loop keeps every path assigned, so no latch.
    w_beat = '0;
    for (int i = 0; i < NUM_BYTES_IN; i++) begin
      w_beat[8*i +: 8] = data_in[8*(NUM_BYTES_IN-1-i) +: 8];
    end
  end
`else
  assign w_beat = data_in;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_consume   = r_out_valid && out_ready;
  assign w_hold_free = !r_out_valid || out_ready;
  assign w_last      = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_asm_next  = {w_asm[OUT_W-IN_W-1:0], w_beat};

  // The last beat is forwarded straight into holding in the cycle it arrives.
  assign w_hold_src  = (r_state == WAIT) ? w_asm : w_asm_next;
  assign w_load_hold = !clear &&
                       (((r_state == FILL) && w_accept && w_last && w_hold_free) ||
                        ((r_state == WAIT) && w_consume));

  flexbyte_stp_sr #(
    .NUM_BYTES_IN (NUM_BYTES_IN),
    .NUM_BYTES_OUT(NUM_BYTES_OUT)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .shift_enable(w_accept),
    .clear       (clear),
    .data_in     (w_beat),
    .data_out    (w_asm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: if (!clear && w_accept && w_last && !w_hold_free) w_state_next = WAIT;
      WAIT: if (clear || w_consume) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready = (r_state == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (clear || w_load_hold) begin
      r_beat_cnt <= '0;
    end else if (w_accept && !w_last) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_hold) begin
      r_hold      <= w_hold_src;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign data_out  = r_hold;
  assign out_valid = r_out_valid;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_rx_sr.sv
// Self-checking bench for rx_sr: directed vector table, hand-written corner
// sequences, and random traffic against a queue-based block model.
module tb_rx_sr;

  localparam int IN_W  = 64;
  localparam int OUT_W = 128;
  localparam int BEATS = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic [IN_W-1:0]  data_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] data_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [0:0]       beat_cnt;

  rx_sr dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: beats queue + one holding slot
  logic [IN_W-1:0]  m_q[$];
  logic [OUT_W-1:0] m_hold;
  bit               m_hold_v;

  function automatic logic [IN_W-1:0] swap(input logic [IN_W-1:0] d);
`ifdef RX_SR_BYTE_SWAP_EN
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W / 8; i++) r[8*i +: 8] = d[IN_W-8-8*i +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [OUT_W-1:0] blk2(input logic [IN_W-1:0] a,
                                            input logic [IN_W-1:0] b);
    return {swap(a), swap(b)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hold   = '0;
    m_hold_v = 1'b0;
  endtask

  task automatic model_step(input bit iv, input logic [IN_W-1:0] d,
                            input bit ordy, input bit clr);
    bit consume, hold_free;
    consume   = m_hold_v && ordy;
    hold_free = !m_hold_v || ordy;
    if (clr) begin
      m_q.delete();
      if (consume) m_hold_v = 1'b0;
    end else begin
      if (iv && m_q.size() < BEATS) m_q.push_back(swap(d));
      if (m_q.size() == BEATS && hold_free) begin
        m_hold = '0;
        foreach (m_q[i]) m_hold = (m_hold << IN_W) | OUT_W'(m_q[i]);
        m_hold_v = 1'b1;
        m_q.delete();
      end else if (consume) begin
        m_hold_v = 1'b0;
      end
    end
  endtask

  // ---------------- vector application
  typedef struct {
    bit               iv;
    logic [IN_W-1:0]  d;
    bit               ordy;
    bit               clr;
    bit               e_ov;
    logic [OUT_W-1:0] e_do;
    bit               e_ir;
    int               e_cnt;
  } vec_t;

  int obs_ov, obs_ir_low;

  task automatic apply(input vec_t v, input bit use_model, input string tag);
    in_valid  = v.iv;
    data_in   = v.d;
    out_ready = v.ordy;
    clear     = v.clr;
    @(negedge clk);
    if (out_valid) obs_ov++;
    if (!in_ready) obs_ir_low++;
    if (use_model) begin
      check({tag, ".out_valid"}, 128'(out_valid), 128'(m_hold_v));
      check({tag, ".data_out"},  data_out,        m_hold);
      check({tag, ".in_ready"},  128'(in_ready),  128'(m_q.size() < BEATS));
      check({tag, ".beat_cnt"},  128'(beat_cnt),
            128'((m_q.size() >= BEATS) ? BEATS - 1 : m_q.size()));
    end else begin
      check({tag, ".out_valid"}, 128'(out_valid), 128'(v.e_ov));
      check({tag, ".data_out"},  data_out,        v.e_do);
      check({tag, ".in_ready"},  128'(in_ready),  128'(v.e_ir));
      check({tag, ".beat_cnt"},  128'(beat_cnt),  128'(v.e_cnt));
    end
    model_step(v.iv, v.d, v.ordy, v.clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit iv, logic [IN_W-1:0] d, bit ordy, bit clr,
                              bit e_ov, logic [OUT_W-1:0] e_do, bit e_ir, int e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
    v.e_ov = e_ov; v.e_do = e_do; v.e_ir = e_ir; v.e_cnt = e_cnt;
    return v;
  endfunction

`ifdef RX_SR_BYTE_SWAP_EN
  localparam logic [IN_W-1:0]  T1_A   = 64'h0001020304050607;
  localparam logic [IN_W-1:0]  T1_B   = 64'h08090A0B0C0D0E0F;
  localparam logic [OUT_W-1:0] T1_EXP = 128'h07060504030201000F0E0D0C0B0A0908;
`else
  localparam logic [IN_W-1:0]  T1_A   = 64'h0011223344556677;
  localparam logic [IN_W-1:0]  T1_B   = 64'h8899AABBCCDDEEFF;
  localparam logic [OUT_W-1:0] T1_EXP = 128'h00112233445566778899AABBCCDDEEFF;
`endif

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tab[$];
    logic [IN_W-1:0] c1, c2, c3, c4, e1, e2;
    vec_t v;
    c1 = 64'hC1C1_0000_0000_0001; c2 = 64'hC2C2_0000_0000_0002;
    c3 = 64'hC3C3_0000_0000_0003; c4 = 64'hC4C4_0000_0000_0004;
    e1 = 64'hE1E1_5555_AAAA_0001; e2 = 64'hE2E2_AAAA_5555_0002;

    // basic block, out_ready high
    tab.push_back(mk(1, T1_A, 1, 0, 0, '0,     1, 0));
    tab.push_back(mk(1, T1_B, 1, 0, 0, '0,     1, 1));
    tab.push_back(mk(0, '0,   1, 0, 1, T1_EXP, 1, 0));
    tab.push_back(mk(0, '0,   1, 0, 0, T1_EXP, 1, 0));
    // backpressure: block 1 holds, block 2 waits in assembly
    tab.push_back(mk(1, c1, 0, 0, 0, T1_EXP,       1, 0));
    tab.push_back(mk(1, c2, 0, 0, 0, T1_EXP,       1, 1));
    tab.push_back(mk(1, c3, 0, 0, 1, blk2(c1, c2), 1, 0));
    tab.push_back(mk(1, c4, 0, 0, 1, blk2(c1, c2), 1, 1));
    tab.push_back(mk(1, 64'hDEAD, 0, 0, 1, blk2(c1, c2), 0, 1));
    tab.push_back(mk(0, '0, 1, 0, 1, blk2(c1, c2), 0, 1));
    tab.push_back(mk(0, '0, 0, 0, 1, blk2(c3, c4), 1, 0));
    tab.push_back(mk(0, '0, 1, 0, 1, blk2(c3, c4), 1, 0));
    // clear beats a simultaneous in-beat and drops the partial block
    tab.push_back(mk(1, 64'hD1, 1, 0, 0, blk2(c3, c4), 1, 0));
    tab.push_back(mk(1, 64'hD2, 1, 1, 0, blk2(c3, c4), 1, 1));
    tab.push_back(mk(1, e1, 1, 0, 0, blk2(c3, c4), 1, 0));
    tab.push_back(mk(1, e2, 1, 0, 0, blk2(c3, c4), 1, 1));
    tab.push_back(mk(0, '0, 1, 0, 1, blk2(e1, e2), 1, 0));
    tab.push_back(mk(0, '0, 1, 0, 0, blk2(e1, e2), 1, 0));

    do_reset();
    for (int i = 0; i < tab.size(); i++) apply(tab[i], 1'b0, $sformatf("tab%0d", i));

    // back-to-back beats with out_ready held high: three blocks, no stall
    do_reset();
    obs_ov = 0; obs_ir_low = 0;
    for (int i = 0; i < 8; i++) begin
      v = mk(i < 6, {$urandom, $urandom}, 1, 0, 0, '0, 0, 0);
      apply(v, 1'b1, $sformatf("b2b%0d", i));
    end
    check("b2b.blocks", 128'(obs_ov), 128'(3));
    check("b2b.in_ready_low", 128'(obs_ir_low), 128'(0));

    // asynchronous reset with a held block and a partial beat
    do_reset();
    apply(mk(1, 64'h1111, 0, 0, 0, '0, 0, 0), 1'b1, "ar0");
    apply(mk(1, 64'h2222, 0, 0, 0, '0, 0, 0), 1'b1, "ar1");
    apply(mk(1, 64'h3333, 0, 0, 0, '0, 0, 0), 1'b1, "ar2");
    in_valid = 1'b0;
    check("arst.pre_out_valid", 128'(out_valid), 128'(1));
    check("arst.pre_beat_cnt",  128'(beat_cnt),  128'(1));
    #2 rst = 1'b1;
    #1;
    check("arst.out_valid", 128'(out_valid), 128'(0));
    check("arst.beat_cnt",  128'(beat_cnt),  128'(0));
    check("arst.data_out",  data_out,        '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      v = mk($urandom_range(0, 3) != 0, {$urandom, $urandom},
             $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 0, '0, 0, 0);
      apply(v, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
